// File: rtl/apb3_rr_arbiter.sv
// Round-robin arbiter letting NREQ requesters share one APB3 master.
// Issues one transfer at a time and aborts transfers that stall for too long.
module apb3_rr_arbiter #(
  parameter int NREQ    = 4,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic               PCLK,
  input  logic               PRESETn,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  input  logic [NREQ-1:0]    req_write,
  output logic [NREQ-1:0]    req_ready,
  output logic [NREQ-1:0]    rsp_valid,
  output logic [DW-1:0]      rsp_rdata,
  output logic               rsp_err,
  output logic               data_valid,
  output logic [AW-1:0]      addr,
  output logic [DW-1:0]      data,
  output logic               data_dir,
  input  logic               transaction_done,
  input  logic [DW-1:0]      data_out,
  input  logic               pslverr,
  output logic               busy,
  output logic               timeout_err
);

  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t          state, state_nxt;
  logic [GW-1:0]   grant, last_grant, pick;
  logic [CW-1:0]   wait_cnt;
  logic            any_req, found, wait_expire;
  int              idx;

  assign any_req = |req_valid;
  // The counter is compared before it increments, so the abort fires after
  // exactly TIMEOUT WAIT cycles.
  assign wait_expire = (wait_cnt == CW'(TIMEOUT - 1));

  // NOTE: every variable gets a default before the loop/case so no latch is inferred.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(last_grant) + 1 + k) % NREQ;
      if (!found && req_valid[idx]) begin
        pick  = GW'(idx);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (transaction_done || wait_expire) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register sees the pre-edge values of the others.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      grant       <= '0;
      last_grant  <= GW'(NREQ - 1);
      wait_cnt    <= '0;
      req_ready   <= '0;
      rsp_valid   <= '0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      data_valid  <= 1'b0;
      addr        <= '0;
      data        <= '0;
      data_dir    <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      // Pulse outputs default low; each state raises only what it owns.
      req_ready   <= '0;
      rsp_valid   <= '0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      data_valid  <= 1'b0;
      timeout_err <= 1'b0;
      busy        <= (state_nxt != IDLE);
      case (state)
        IDLE: begin
          if (any_req) begin
            grant      <= pick;
            req_ready  <= NREQ'(1) << pick;
            data_valid <= 1'b1;
            addr       <= req_addr[int'(pick)*AW +: AW];
            data       <= req_write[pick] ? req_wdata[int'(pick)*DW +: DW] : '0;
            data_dir   <= req_write[pick];
          end
        end
        ISSUE: wait_cnt <= '0;
        WAIT: begin
          wait_cnt <= wait_cnt + CW'(1);
          if (transaction_done) begin
            rsp_valid <= NREQ'(1) << grant;
            rsp_rdata <= data_dir ? '0 : data_out;
            rsp_err   <= pslverr;
          end else if (wait_expire) begin
            rsp_valid   <= NREQ'(1) << grant;
            rsp_err     <= 1'b1;
            timeout_err <= 1'b1;
          end
        end
        RESP: begin
          last_grant <= grant;
          addr       <= '0;
          data       <= '0;
          data_dir   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_apb3_rr_arbiter.sv
// Self-checking bench for apb3_rr_arbiter: directed scenarios plus randomized
// transfers checked against a round-robin reference model.
module tb_apb3_rr_arbiter;

  localparam int NREQ    = 4;
  localparam int AW      = 32;
  localparam int DW      = 32;
  localparam int TIMEOUT = 16;

  logic               PCLK = 1'b0;
  logic               PRESETn;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;
  logic [NREQ-1:0]    req_write;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ-1:0]    rsp_valid;
  logic [DW-1:0]      rsp_rdata;
  logic               rsp_err;
  logic               data_valid;
  logic [AW-1:0]      addr;
  logic [DW-1:0]      data;
  logic               data_dir;
  logic               transaction_done;
  logic [DW-1:0]      data_out;
  logic               pslverr;
  logic               busy;
  logic               timeout_err;

  apb3_rr_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .req_valid(req_valid), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_write(req_write), .req_ready(req_ready), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .data_valid(data_valid),
    .addr(addr), .data(data), .data_dir(data_dir),
    .transaction_done(transaction_done), .data_out(data_out), .pslverr(pslverr),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 PCLK = ~PCLK;

  int errors = 0;
  int checks = 0;

  // Reference model state: last served requester and each requester's fields.
  int            lg = NREQ - 1;
  logic [AW-1:0] r_addr  [NREQ];
  logic [DW-1:0] r_wdata [NREQ];
  logic          r_write [NREQ];

  function automatic logic [NREQ-1:0] onehot(input int i);
    logic [NREQ-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // Round-robin rule: first requesting index after the last one served.
  function automatic int exp_grant(input logic [NREQ-1:0] mask);
    for (int k = 1; k <= NREQ; k++) begin
      if (mask[(lg + k) % NREQ]) return (lg + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic tick;
    @(posedge PCLK);
    #1;
  endtask

  task automatic drive_fields;
    for (int i = 0; i < NREQ; i++) begin
      req_addr[i*AW +: AW]  = r_addr[i];
      req_wdata[i*DW +: DW] = r_wdata[i];
      req_write[i]          = r_write[i];
    end
  endtask

  task automatic check_idle(input string tag);
    checks++;
    if ({busy, req_ready, rsp_valid, data_valid, timeout_err, rsp_err,
         addr, data, data_dir, rsp_rdata} !== '0) begin
      errors++;
      $display("FAIL %s idle: busy=%b rdy=%b rsp=%b dv=%b to=%b err=%b addr=%h data=%h dir=%b rd=%h (want all 0)",
               tag, busy, req_ready, rsp_valid, data_valid, timeout_err, rsp_err,
               addr, data, data_dir, rsp_rdata);
    end
  endtask

  // One complete transfer from IDLE back to IDLE. done_at is the WAIT-cycle
  // index at which the master completes; beyond TIMEOUT-1 it never does.
  task automatic run_transfer(input logic [NREQ-1:0] mask, input int done_at,
                              input logic perr, input logic [DW-1:0] dout,
                              input string tag, output logic [NREQ-1:0] granted);
    int            g, wait_len;
    logic          exp_to, exp_err;
    logic [DW-1:0] exp_data, exp_rd;
    g        = exp_grant(mask);
    exp_data = r_write[g] ? r_wdata[g] : '0;
    exp_to   = (done_at > TIMEOUT - 1);
    wait_len = exp_to ? TIMEOUT : done_at + 1;
    exp_rd   = (exp_to || r_write[g]) ? '0 : dout;
    exp_err  = exp_to ? 1'b1 : perr;

    req_valid = mask;
    drive_fields();
    tick();
    granted = req_ready;
    checks++;
    if ({req_ready, data_valid, busy, addr, data, data_dir, rsp_valid} !==
        {onehot(g), 1'b1, 1'b1, r_addr[g], exp_data, r_write[g], {NREQ{1'b0}}}) begin
      errors++;
      $display("FAIL %s issue: rdy=%b dv=%b busy=%b addr=%h data=%h dir=%b rsp=%b, want rdy=%b dv=1 busy=1 addr=%h data=%h dir=%b rsp=0",
               tag, req_ready, data_valid, busy, addr, data, data_dir, rsp_valid,
               onehot(g), r_addr[g], exp_data, r_write[g]);
    end

    // Served requester drops; a done pulse during ISSUE must be ignored.
    req_valid[g]     = 1'b0;
    transaction_done = 1'b1;
    tick();
    transaction_done = 1'b0;

    for (int c = 0; c < wait_len; c++) begin
      checks++;
      if ({req_ready, data_valid, busy, rsp_valid, timeout_err, addr, data, data_dir} !==
          {{NREQ{1'b0}}, 1'b0, 1'b1, {NREQ{1'b0}}, 1'b0, r_addr[g], exp_data, r_write[g]}) begin
        errors++;
        $display("FAIL %s wait[%0d]: rdy=%b dv=%b busy=%b rsp=%b to=%b addr=%h data=%h dir=%b, want busy=1 addr=%h data=%h dir=%b rest 0",
                 tag, c, req_ready, data_valid, busy, rsp_valid, timeout_err, addr, data,
                 data_dir, r_addr[g], exp_data, r_write[g]);
      end
      transaction_done = (c == done_at);
      data_out         = dout;
      pslverr          = perr;
      tick();
      transaction_done = 1'b0;
      data_out         = $urandom;
      pslverr          = 1'($urandom);
    end

    checks++;
    if ({rsp_valid, rsp_rdata, rsp_err, timeout_err, busy, req_ready, data_valid,
         addr, data, data_dir} !==
        {onehot(g), exp_rd, exp_err, exp_to, 1'b1, {NREQ{1'b0}}, 1'b0,
         r_addr[g], exp_data, r_write[g]}) begin
      errors++;
      $display("FAIL %s resp: rsp=%b rd=%h err=%b to=%b busy=%b addr=%h dir=%b, want rsp=%b rd=%h err=%b to=%b busy=1 addr=%h dir=%b",
               tag, rsp_valid, rsp_rdata, rsp_err, timeout_err, busy, addr, data_dir,
               onehot(g), exp_rd, exp_err, exp_to, r_addr[g], r_write[g]);
    end

    // A done pulse during RESP must also be ignored.
    transaction_done = 1'b1;
    tick();
    transaction_done = 1'b0;
    check_idle(tag);
    lg = g;
  endtask

  task automatic apply_reset;
    PRESETn          = 1'b0;
    req_valid        = '0;
    transaction_done = 1'b0;
    pslverr          = 1'b0;
    data_out         = '0;
    repeat (2) tick();
    check_idle("in_reset");
    PRESETn = 1'b1;
    tick();
    check_idle("post_reset");
    lg = NREQ - 1;
  endtask

  task automatic test_reset;
    PRESETn = 1'b1;
    #2 PRESETn = 1'b0;
    #1 check_idle("async_reset");
    apply_reset();
  endtask

  task automatic test_idle_no_req;
    req_valid = '0;
    for (int i = 0; i < 3; i++) begin
      transaction_done = 1'(i % 2);
      tick();
      check_idle("idle_no_req");
    end
    transaction_done = 1'b0;
  endtask

  task automatic test_single_write;
    logic [NREQ-1:0] gr;
    r_addr[2] = 32'h10; r_wdata[2] = 32'hA5A5_A5A5; r_write[2] = 1'b1;
    run_transfer(4'b0100, 1, 1'b0, 32'hFFFF_0000, "single_write", gr);
  endtask

  task automatic test_read;
    logic [NREQ-1:0] gr;
    r_addr[1] = 32'h20; r_wdata[1] = 32'h1234_5678; r_write[1] = 1'b0;
    run_transfer(4'b0010, 0, 1'b0, 32'hDEAD_BEEF, "read", gr);
  endtask

  task automatic test_round_robin;
    int              order [5] = '{0, 1, 2, 3, 0};
    logic [NREQ-1:0] gr;
    apply_reset();
    for (int t = 0; t < 5; t++) begin
      for (int i = 0; i < NREQ; i++) begin
        r_addr[i] = 32'h100 * i; r_wdata[i] = $urandom; r_write[i] = 1'(i % 2);
      end
      run_transfer('1, 1, 1'b0, $urandom, "round_robin", gr);
      checks++;
      if (gr !== onehot(order[t])) begin
        errors++;
        $display("FAIL round_robin order[%0d]: got %b want %b", t, gr, onehot(order[t]));
      end
    end
  endtask

  task automatic test_timeout;
    logic [NREQ-1:0] gr;
    r_addr[3] = 32'h30; r_write[3] = 1'b0;
    run_transfer(4'b1000, 1000, 1'b0, 32'hCAFE_F00D, "timeout", gr);
  endtask

  task automatic test_slave_error;
    logic [NREQ-1:0] gr;
    r_addr[0] = 32'h40; r_write[0] = 1'b0;
    run_transfer(4'b0001, 2, 1'b1, 32'h0BAD_0BAD, "slverr", gr);
    r_addr[1] = 32'h44; r_wdata[1] = 32'h5A5A_5A5A; r_write[1] = 1'b1;
    run_transfer(4'b0010, TIMEOUT - 1, 1'b0, 32'h0, "done_at_timeout", gr);
  endtask

  task automatic test_reset_mid;
    logic [NREQ-1:0] gr;
    r_addr[2] = 32'h50; r_write[2] = 1'b0;
    req_valid = 4'b0100;
    drive_fields();
    repeat (3) tick();
    req_valid = '0;
    #2 PRESETn = 1'b0;
    #1 check_idle("reset_mid_async");
    for (int i = 0; i < 3; i++) begin
      transaction_done = 1'b1;
      tick();
      check_idle("reset_mid_hold");
    end
    transaction_done = 1'b0;
    PRESETn = 1'b1;
    tick();
    check_idle("reset_mid_release");
    lg = NREQ - 1;
    r_addr[1] = 32'h60; r_wdata[1] = 32'h7777_8888; r_write[1] = 1'b1;
    r_addr[3] = 32'h64; r_write[3] = 1'b0;
    run_transfer(4'b1010, 3, 1'b0, 32'h0, "after_reset", gr);
  endtask

  task automatic test_random;
    logic [NREQ-1:0] gr, mask;
    mask = '0;
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < NREQ; i++) begin
        r_addr[i] = $urandom; r_wdata[i] = $urandom; r_write[i] = 1'($urandom);
      end
      // Requesters not yet served keep requesting; new ones may join.
      mask = mask | NREQ'($urandom_range(0, (1 << NREQ) - 1));
      if (mask == '0) mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      run_transfer(mask, $urandom_range(0, TIMEOUT + 1), 1'($urandom), $urandom,
                   "random", gr);
      mask = mask & ~gr;
    end
    req_valid = '0;
  endtask

  initial begin
    PRESETn          = 1'b1;
    req_valid        = '0;
    req_addr         = '0;
    req_wdata        = '0;
    req_write        = '0;
    transaction_done = 1'b0;
    data_out         = '0;
    pslverr          = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      r_addr[i] = '0; r_wdata[i] = '0; r_write[i] = 1'b0;
    end
    test_reset();
    test_idle_no_req();
    test_single_write();
    test_read();
    test_round_robin();
    test_timeout();
    test_slave_error();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/apb3_rr_arbiter.md
APB3_RR_ARBITER -- requirements
Module: apb3_rr_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of requesters sharing one APB3 master.
REQ-002 Parameter AW, default 32, address width; DW, default 32, data width.
REQ-003 Parameter TIMEOUT, default 16, maximum WAIT-state cycles before abort.
REQ-004 Clocking: one clock; reset is asynchronous and active-low.
REQ-005 PCLK  in  1  sole clock, all state on rising edge.
REQ-006 PRESETn  in  1  asynchronous active-low reset.
REQ-007 req_valid  in  NREQ  per-requester transfer request.
REQ-008 req_addr  in  NREQ*AW  packed addresses, slice i = requester i.
REQ-009 req_wdata  in  NREQ*DW  packed write data.
REQ-010 req_write  in  NREQ  per-requester direction, 1 = write.
REQ-011 req_ready  out  NREQ  one-hot accept pulse.
REQ-012 rsp_valid  out  NREQ  one-hot completion pulse.
REQ-013 rsp_rdata  out  DW  read data, valid with rsp_valid.
REQ-014 rsp_err  out  1  slave error or timeout, valid with rsp_valid.
REQ-015 data_valid  out  1  start pulse to APB3 master.
REQ-016 addr / data / data_dir  out  AW / DW / 1  transfer fields to master.
REQ-017 transaction_done  in  1  master completion pulse; data_out  in  DW  master read data; pslverr  in  1  sampled PSLVERR.
REQ-018 busy  out  1  high in any state other than IDLE; timeout_err  out  1  one-cycle abort pulse.

Function
REQ-019 FSM states IDLE, ISSUE, WAIT, RESP; all outputs registered.
REQ-020 IDLE: when any req_valid is high, grant g = first set index searching upward from (last_grant+1) mod NREQ, wrapping; latch addr, wdata, write of g; go to ISSUE next cycle.
REQ-021 IDLE with no req_valid: remain IDLE, no outputs asserted.
REQ-022 ISSUE (exactly one cycle): req_ready[g]=1, data_valid=1; next state WAIT.
REQ-023 addr, data, data_dir hold latched values from ISSUE through RESP; data = 0 when data_dir = 0.
REQ-024 WAIT: cycle counter starts at 0 on entry, increments each cycle.
REQ-025 WAIT with transaction_done=1: capture rsp_rdata = data_out if read else 0; rsp_err = pslverr; go RESP.
REQ-026 WAIT with counter reaching TIMEOUT and no transaction_done: timeout_err=1 for one cycle, rsp_err=1, rsp_rdata=0, go RESP.
REQ-027 transaction_done and timeout in the same cycle: done wins, no timeout_err.
REQ-028 RESP (exactly one cycle): rsp_valid[g]=1 with rsp_rdata, rsp_err; last_grant=g; next state IDLE.
REQ-029 transaction_done in IDLE, ISSUE or RESP is ignored.
REQ-030 Requesters hold req_valid and fields stable until req_ready; a request dropped before grant is not served.
REQ-031 A requester re-asserting after its response is re-arbitrated fairly; no requester waits more than NREQ transfers.
REQ-032 Minimum turnaround: request seen in IDLE at cycle 0 -> ISSUE cycle 1 -> earliest RESP cycle 3 -> IDLE cycle 4.
REQ-033 rsp_rdata, rsp_err, rsp_valid return to 0 outside RESP.

Reset
REQ-034 PRESETn low forces immediately: state IDLE, all outputs 0, counter 0, last_grant = NREQ-1 (requester 0 highest priority first).
REQ-035 Reset mid-transfer aborts it with no rsp_valid; after release the arbiter starts from IDLE.

Verification
REQ-036 Single write: req_valid[2]=1, addr 0x10, wdata 0xA5A5A5A5 -> ISSUE with data_valid=1, addr 0x10, data_dir=1; done after 2 cycles -> rsp_valid=4'b0100, rsp_err=0, rsp_rdata=0.
REQ-037 Read: req 1 reads 0x20, master returns data_out 0xDEADBEEF with done -> rsp_valid[1]=1, rsp_rdata=0xDEADBEEF.
REQ-038 Round-robin: all four req_valid held high from reset -> grant order 0,1,2,3,0 across five transfers.
REQ-039 Timeout: transaction_done never asserted -> timeout_err pulse TIMEOUT cycles after WAIT entry, rsp_err=1, rsp_rdata=0, then IDLE.
REQ-040 Slave error: done with pslverr=1 -> rsp_err=1 on matching rsp_valid; done and timeout coinciding -> no timeout_err.
REQ-041 Reset asserted during WAIT -> outputs 0 same cycle, no rsp_valid; next request after release served normally.
